// File: rtl/mem_port_ctrl_pkg.sv
// Shared state encoding and default parameters for the SRAM port controller.
package mem_port_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_SRAM_AW     = 12;
  localparam int DEF_WAIT_CYCLES = 2;
  // Wide enough for the largest legal wait-state count (15).
  localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_port_ctrl_wait_cnt.sv
// Wait-state down-counter: parallel load, saturating decrement, zero flag.
module mem_wait_cnt
  import mem_port_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-port SRAM access controller: one request at a time, fixed wait states,
// illegal (misaligned / out-of-range) requests are acked with an error.
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SRAM_AW     = DEF_SRAM_AW,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               memReq,
  input  logic [ADDR_W-1:0]  memAddr,
  input  logic               memWr,
  input  logic [DATA_W-1:0]  memDataIn,
  output logic               memBusy,
  output logic               memAck,
  output logic               memErr,
  output logic [DATA_W-1:0]  memDataOut,
  output logic               sramEn,
  output logic               sramWe,
  output logic [SRAM_AW-1:0] sramAddr,
  output logic [DATA_W-1:0]  sramWData,
  input  logic [DATA_W-1:0]  sramRData
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t           state;
  logic             legal;
  logic             accept;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt;

  // Word aligned and inside the SRAM window.
  always_comb begin
    legal  = (memAddr[1:0] == 2'b00) && ((memAddr >> (SRAM_AW + 2)) == '0);
    accept = memReq && ((state == ST_IDLE) || (state == ST_DONE));
  end

  // Loading on the ACCESS->WAIT edge gives exactly WAIT_CYCLES cycles in WAIT.
  mem_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_ACCESS),
    .dec      (state == ST_WAIT),
    .load_val (WAIT_LOAD),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      memBusy    <= 1'b0;
      memAck     <= 1'b0;
      memErr     <= 1'b0;
      memDataOut <= '0;
      sramEn     <= 1'b0;
      sramWe     <= 1'b0;
      sramAddr   <= '0;
      sramWData  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          memAck <= 1'b0;
          memErr <= 1'b0;
          state  <= ST_IDLE;
          if (accept) begin
            if (legal) begin
              state     <= ST_ACCESS;
              memBusy   <= 1'b1;
              sramEn    <= 1'b1;
              sramWe    <= memWr;
              sramAddr  <= memAddr[SRAM_AW+1:2];
              sramWData <= memDataIn;
            end else begin
              // Rejected without touching the SRAM.
              state  <= ST_DONE;
              memAck <= 1'b1;
              memErr <= 1'b1;
            end
          end
        end
        ST_ACCESS: state <= ST_WAIT;
        ST_WAIT: begin
          if (cnt_zero) begin
            state   <= ST_DONE;
            memBusy <= 1'b0;
            sramEn  <= 1'b0;
            sramWe  <= 1'b0;
            memAck  <= 1'b1;
            memErr  <= 1'b0;
            if (!sramWe)
              memDataOut <= sramRData;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: main instance at 2 wait states plus
// 1- and 15-wait-state instances for latency checks.
module tb_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memWr;
  logic [31:0] memDataIn;

  logic        memBusy, memAck, memErr, sramEn, sramWe;
  logic [31:0] memDataOut, sramWData, sramRData;
  logic [11:0] sramAddr;

  logic        busy1, ack1, err1, en1, we1;
  logic [31:0] dout1, wd1, rd1;
  logic [11:0] sa1;

  logic        busy15, ack15, err15, en15, we15;
  logic [31:0] dout15, wd15, rd15;
  logic [11:0] sa15;

  logic        preload;
  logic [31:0] mem [0:4095];

  int tests = 0;
  int fails = 0;
  int a1, a2, a15;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) mem[4] <= 32'hDEAD_BEEF;
    else if (sramEn && sramWe) mem[sramAddr] <= sramWData;
  end

  assign sramRData = sramEn ? mem[sramAddr] : 32'h0;
  assign rd1  = {20'h0, sa1};
  assign rd15 = {20'h0, sa15};

  mem_port_ctrl #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .memReq(memReq), .memAddr(memAddr), .memWr(memWr),
    .memDataIn(memDataIn), .memBusy(memBusy), .memAck(memAck), .memErr(memErr),
    .memDataOut(memDataOut), .sramEn(sramEn), .sramWe(sramWe), .sramAddr(sramAddr),
    .sramWData(sramWData), .sramRData(sramRData)
  );

  mem_port_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .memReq(memReq), .memAddr(memAddr), .memWr(memWr),
    .memDataIn(memDataIn), .memBusy(busy1), .memAck(ack1), .memErr(err1),
    .memDataOut(dout1), .sramEn(en1), .sramWe(we1), .sramAddr(sa1),
    .sramWData(wd1), .sramRData(rd1)
  );

  mem_port_ctrl #(.WAIT_CYCLES(15)) dut15 (
    .clk(clk), .reset(reset), .memReq(memReq), .memAddr(memAddr), .memWr(memWr),
    .memDataIn(memDataIn), .memBusy(busy15), .memAck(ack15), .memErr(err15),
    .memDataOut(dout15), .sramEn(en15), .sramWe(we15), .sramAddr(sa15),
    .sramWData(wd15), .sramRData(rd15)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"},  32'(memBusy),  32'h0);
    chk({tag, "_ack"},   32'(memAck),   32'h0);
    chk({tag, "_err"},   32'(memErr),   32'h0);
    chk({tag, "_dout"},  memDataOut,    32'h0);
    chk({tag, "_en"},    32'(sramEn),   32'h0);
    chk({tag, "_we"},    32'(sramWe),   32'h0);
    chk({tag, "_saddr"}, 32'(sramAddr), 32'h0);
    chk({tag, "_wdata"}, sramWData,     32'h0);
  endtask

  initial begin
    reset = 1'b1; memReq = 1'b0; memAddr = '0; memWr = 1'b0; memDataIn = '0;
    preload = 1'b1;
    step(); step();
    chk_reset_outs("rst");
    reset = 1'b0; preload = 1'b0;
    step();

    // Read 0x10 -> word 4
    memReq = 1'b1; memAddr = 32'h10; memWr = 1'b0;
    step(); memReq = 1'b0;
    chk("rd_busy_c1", 32'(memBusy), 32'h1);
    chk("rd_en_c1",   32'(sramEn),  32'h1);
    chk("rd_we_c1",   32'(sramWe),  32'h0);
    chk("rd_addr_c1", 32'(sramAddr), 32'h4);
    chk("rd_ack_c1",  32'(memAck),  32'h0);
    step(); chk("rd_busy_c2", 32'(memBusy), 32'h1);
    step(); chk("rd_busy_c3", 32'(memBusy), 32'h1);
    step();
    chk("rd_ack_c4",  32'(memAck),  32'h1);
    chk("rd_err_c4",  32'(memErr),  32'h0);
    chk("rd_data_c4", memDataOut,   32'hDEAD_BEEF);
    chk("rd_busy_c4", 32'(memBusy), 32'h0);
    chk("rd_en_c4",   32'(sramEn),  32'h0);
    step(); chk("rd_ack_c5", 32'(memAck), 32'h0);

    // Write 0x20 <- 0x12345678
    memReq = 1'b1; memAddr = 32'h20; memWr = 1'b1; memDataIn = 32'h1234_5678;
    step(); memReq = 1'b0; memWr = 1'b0; memDataIn = '0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_en",    32'(sramEn),   32'h1);
      chk("wr_we",    32'(sramWe),   32'h1);
      chk("wr_addr",  32'(sramAddr), 32'h8);
      chk("wr_wdata", sramWData,     32'h1234_5678);
      chk("wr_ack",   32'(memAck),   32'h0);
      step();
    end
    chk("wr_ack_c4",  32'(memAck), 32'h1);
    chk("wr_err_c4",  32'(memErr), 32'h0);
    chk("wr_dout_hold", memDataOut, 32'hDEAD_BEEF);
    step();

    // Readback
    memReq = 1'b1; memAddr = 32'h20;
    step(); memReq = 1'b0;
    step(); step(); step();
    chk("rb_ack",  32'(memAck), 32'h1);
    chk("rb_data", memDataOut,  32'h1234_5678);
    step();

    // Misaligned
    memReq = 1'b1; memAddr = 32'h2;
    step(); memReq = 1'b0;
    chk("mis_ack",  32'(memAck),  32'h1);
    chk("mis_err",  32'(memErr),  32'h1);
    chk("mis_en",   32'(sramEn),  32'h0);
    chk("mis_busy", 32'(memBusy), 32'h0);
    chk("mis_dout", memDataOut,   32'h1234_5678);
    step();
    chk("mis_ack_c2", 32'(memAck), 32'h0);
    chk("mis_err_c2", 32'(memErr), 32'h0);

    // Out of range
    memReq = 1'b1; memAddr = 32'h0001_0000;
    step(); memReq = 1'b0;
    chk("oor_ack",  32'(memAck), 32'h1);
    chk("oor_err",  32'(memErr), 32'h1);
    chk("oor_en",   32'(sramEn), 32'h0);
    chk("oor_dout", memDataOut,  32'h1234_5678);
    step();

    // Back-to-back: memReq held high, address changes while busy
    memReq = 1'b1; memAddr = 32'h10;
    step(); memAddr = 32'h20;
    step(); step(); step();
    chk("b2b_ack1",  32'(memAck), 32'h1);
    chk("b2b_data1", memDataOut,  32'hDEAD_BEEF);
    step(); memReq = 1'b0;
    chk("b2b_busy_c5", 32'(memBusy),  32'h1);
    chk("b2b_ack_c5",  32'(memAck),   32'h0);
    chk("b2b_addr_c5", 32'(sramAddr), 32'h8);
    step(); step(); step();
    chk("b2b_ack2",  32'(memAck), 32'h1);
    chk("b2b_data2", memDataOut,  32'h1234_5678);
    step();
    chk("b2b_ack_c9",  32'(memAck),  32'h0);
    chk("b2b_busy_c9", 32'(memBusy), 32'h0);

    // Pulse during busy is dropped
    memReq = 1'b1; memAddr = 32'h10;
    step(); memReq = 1'b0;
    step(); memReq = 1'b1; memAddr = 32'h2;
    step(); memReq = 1'b0;
    step();
    chk("pulse_ack",  32'(memAck), 32'h1);
    chk("pulse_err",  32'(memErr), 32'h0);
    chk("pulse_data", memDataOut,  32'hDEAD_BEEF);
    step();
    chk("pulse_ack_c5",  32'(memAck),  32'h0);
    chk("pulse_busy_c5", 32'(memBusy), 32'h0);

    // Reset during WAIT of a read
    memReq = 1'b1; memAddr = 32'h20;
    step(); memReq = 1'b0;
    step(); reset = 1'b1;
    step();
    chk_reset_outs("rstw");
    reset = 1'b0;
    step();
    chk("rstw_ack_after",  32'(memAck),  32'h0);
    chk("rstw_busy_after", 32'(memBusy), 32'h0);
    step();
    chk("rstw_ack_after2", 32'(memAck), 32'h0);

    // Reset wins over a same-edge request
    reset = 1'b1; memReq = 1'b1; memAddr = 32'h10;
    step();
    chk("rstpri_busy", 32'(memBusy), 32'h0);
    chk("rstpri_en",   32'(sramEn),  32'h0);
    reset = 1'b0; memReq = 1'b0;
    for (int i = 0; i < 20; i++) step();

    // Latency across wait-state settings
    memReq = 1'b1; memAddr = 32'h10; memWr = 1'b0;
    step(); memReq = 1'b0;
    a1 = 0; a2 = 0; a15 = 0;
    for (int c = 1; c <= 25; c++) begin
      if (memAck && a2 == 0)  a2 = c;
      if (ack1 && a1 == 0)    a1 = c;
      if (ack15 && a15 == 0)  a15 = c;
      step();
    end
    chk("lat_w2",  32'(a2),  32'd4);
    chk("lat_w1",  32'(a1),  32'd3);
    chk("lat_w15", 32'(a15), 32'd17);
    chk("lat_dout_w1",  dout1,      32'h4);
    chk("lat_dout_w15", dout15,     32'h4);
    chk("lat_dout_w2",  memDataOut, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
